// File: rtl/block_pkg.sv
// block_pkg: shared encodings, ASCII constants and token helpers for block stream generation
package block_pkg;
  localparam logic [1:0] CMD_BEGIN = 2'd0;
  localparam logic [1:0] CMD_END   = 2'd1;
  localparam logic [1:0] CMD_WORD  = 2'd2;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_B   = 8'h62;
  localparam logic [7:0] ASCII_E   = 8'h65;
  localparam logic [7:0] ASCII_G   = 8'h67;
  localparam logic [7:0] ASCII_I   = 8'h69;
  localparam logic [7:0] ASCII_N   = 8'h6e;
  localparam logic [7:0] ASCII_D   = 8'h64;
  localparam logic [7:0] ASCII_X   = 8'h78;
  localparam logic [7:0] CASE_OFS  = 8'h20;
  localparam logic [2:0] LEN_BEGIN = 3'd5;
  localparam logic [2:0] LEN_END   = 3'd3;
  localparam logic [2:0] LEN_WORD  = 3'd1;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic [1:0] norm_cmd(input logic [1:0] c);
    return (c == 2'd3) ? CMD_WORD : c;
  endfunction
  function automatic logic [2:0] tok_last(input logic [1:0] t);
    return (t == CMD_BEGIN) ? LEN_BEGIN - 3'd1 : (t == CMD_END) ? LEN_END - 3'd1 : LEN_WORD - 3'd1;
  endfunction
endpackage

// File: rtl/block_token_rom.sv
// block_token_rom: (token, index, case) -> ASCII character; spaces past the end of the token
module block_token_rom
  import block_pkg::*;
(
  input  logic [1:0] tok,
  input  logic [2:0] idx,
  input  logic       upper,
  output logic [7:0] ch
);
  logic [7:0] lc;
  always_comb begin
    lc = ASCII_SP;
    case (tok)
      CMD_BEGIN: lc = (idx == 3'd0) ? ASCII_B : (idx == 3'd1) ? ASCII_E : (idx == 3'd2) ? ASCII_G :
                      (idx == 3'd3) ? ASCII_I : (idx == 3'd4) ? ASCII_N : ASCII_SP;
      CMD_END:   lc = (idx == 3'd0) ? ASCII_E : (idx == 3'd1) ? ASCII_N : (idx == 3'd2) ? ASCII_D : ASCII_SP;
      default:   lc = (idx == 3'd0) ? ASCII_X : ASCII_SP;
    endcase
    ch = (upper && lc != ASCII_SP) ? lc - CASE_OFS : lc;
  end
endmodule

// File: rtl/block_stream_gen.sv
// block_stream_gen: turns BEGIN/END/WORD commands into a space-separated ASCII keyword stream and tracks nesting depth
module block_stream_gen
  import block_pkg::*;
#(
  parameter int DEPTH_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic               upper,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               balanced
);
  state_t     state, n_state;
  logic [2:0] idx, n_idx;
  logic [1:0] tok, n_tok;
  logic       up, n_up, accept, done;
  logic [7:0] ch;
  always_comb begin
    accept  = (state == IDLE) && cmd_valid;
    done    = (state == EMIT) && (idx == tok_last(tok));
    n_tok   = accept ? norm_cmd(cmd) : tok;
    n_up    = accept ? upper : up;
    n_state = accept ? EMIT : done ? IDLE : state;
    n_idx   = accept ? 3'd0 : (state == EMIT && !done) ? idx + 3'd1 : idx;
  end
  // the ROM looks at next-state token/index so the output byte lands registered
  block_token_rom u_rom (.tok(n_tok), .idx(n_idx), .upper(n_up), .ch(ch));
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      tok       <= CMD_WORD;
      up        <= 1'b0;
      out       <= ASCII_SP;
      depth     <= '0;
      underflow <= 1'b0;
    end else begin
      state <= n_state;
      idx   <= n_idx;
      tok   <= n_tok;
      up    <= n_up;
      out   <= (n_state == EMIT) ? ch : ASCII_SP;
      if (done && tok == CMD_BEGIN && depth != '1) depth <= depth + DEPTH_W'(1);
      if (done && tok == CMD_END) begin
        if (depth != '0) depth <= depth - DEPTH_W'(1);
        else underflow <= 1'b1;
      end
    end
  end
  assign cmd_ready = (state == IDLE);
  assign balanced  = (depth == '0) && !underflow;
endmodule

// File: doc/block_stream_gen.md
# block_stream_gen

Transmit-side companion to the begin/end block checker. It turns a stream of token commands (BEGIN, END, WORD) into an ASCII byte stream, one byte per clock, in the exact format the checker consumes: keyword, then space separator, with idle filler of spaces. It also tracks nesting depth so the source can predict the checker's verdict. It sits in front of the checker in the test harness and in any design that builds keyword streams.

## Interface
Parameters:
- DEPTH_W, 32, width of the nesting-depth counter (matches checker counter width)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd  in  2  0=BEGIN, 1=END, 2=WORD ("x"), 3=treated as WORD
- upper  in  1  1 = emit token in upper case, sampled with cmd
- cmd_ready  out  1  block can accept a command this cycle
- out  out  8  ASCII byte stream, valid every cycle
- depth  out  DEPTH_W  current open-BEGIN count
- underflow  out  1  sticky: END issued at depth 0
- balanced  out  1  depth==0 and !underflow

## Operation
- States: IDLE, EMIT. Registered char index 0..4, latched token and case.
- IDLE: cmd_ready=1, out=0x20 (space). Accept when cmd_valid && cmd_ready at a rising edge; latch cmd/upper; go to EMIT, index 0.
- EMIT: cmd_ready=0; out = char[index] of token: "begin" (5), "end" (3), "x" (1); upper selects "BEGIN"/"END"/"X". After last char, return to IDLE (which supplies the trailing space separator).
- cmd_valid while cmd_ready=0 is ignored; the source must hold the command.
- Depth update on the edge leaving EMIT: BEGIN -> depth+1, saturating at 2^DEPTH_W-1; END -> depth-1 if depth>0, else depth stays 0 and underflow sets; WORD -> no change.
- underflow clears only on reset. balanced is combinational from depth and underflow.
- Reset (any cycle, including mid-token): state IDLE, out=0x20, cmd_ready=1, depth=0, underflow=0, balanced=1; partial token is abandoned (the checker sees a truncated word followed by spaces).

## Timing
- Accept edge E0. After E0: out = first char. After E0+k: char k+1.
- BEGIN: 'b' after E0 ... 'n' after E4; after E5 out=0x20, cmd_ready=1, depth updated. Next accept earliest at E6: 6 cycles per BEGIN back-to-back.
- END: 4 cycles per command; WORD: 2 cycles per command.
- out, cmd_ready, depth, underflow are registered; no combinational path from cmd_valid/cmd to any output.
- Every token is followed by at least one space cycle; the stream never contains two adjacent tokens.

## Structure
- Shared package block_pkg: cmd encodings (CMD_BEGIN, CMD_END, CMD_WORD), ASCII constants (space, keyword letters), state encoding, token lengths.
- Sub-module block_token_rom: combinational (token, index, upper) -> 8-bit char; pure lookup, reusable by the checker bench.
- Top holds FSM, index counter, depth/underflow registers.

## Test plan
- Reset, no commands for 10 cycles -> out=0x20 every cycle, cmd_ready=1, depth=0, balanced=1.
- BEGIN (upper=0) then END -> bytes "b,e,g,i,n,' ',e,n,d,' '"; depth 1 after the 'n'->space edge, 0 after END; balanced=1 at end; driving the checker yields result=1.
- BEGIN, BEGIN, END upper=1 -> "...BEGIN END"-style bytes in upper case for the END only; final depth=1, balanced=0.
- END at depth 0 -> underflow=1, depth=0, balanced=0; subsequent BEGIN, END leaves underflow=1.
- cmd_valid held high with BEGIN continuously for 3 commands -> exactly 3 accepts at 6-cycle spacing, depth=3.
- reset asserted after 'g' of a BEGIN -> next cycle out=0x20, depth=0, cmd_ready=1; no depth increment from the aborted token.
